// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC and selects the next fetch address
// (sequential, branch, jump, jr, illegal-op and interrupt vectors) with EPC capture.
module pc_sequencer #(
    parameter int unsigned     WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h8000_0000,
    parameter logic [WIDTH-1:0] ILLOP_VEC = 32'h8000_0004,
    parameter logic [WIDTH-1:0] XADR_VEC  = 32'h8000_0008,
    parameter int unsigned     KBIT      = WIDTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       pcsrc,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic [25:0]      jump_index,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             irq,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_4,
    output logic             kernel,
    output logic [WIDTH-1:0] epc,
    output logic             exc_taken,
    output logic             irq_pending,
    output logic [WIDTH-1:0] inst_count
);

    localparam logic [2:0] SRC_SEQ    = 3'd0;
    localparam logic [2:0] SRC_BRANCH = 3'd1;
    localparam logic [2:0] SRC_JUMP   = 3'd2;
    localparam logic [2:0] SRC_JR     = 3'd3;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic             r_exc_taken;
    logic             r_irq_pending;
    logic [WIDTH-1:0] r_inst_count;

    logic [WIDTH-1:0] w_pc_plus_4;
    logic [WIDTH-1:0] w_branch;
    logic [WIDTH-1:0] w_jump;
    logic [WIDTH-1:0] w_jr;
    logic [WIDTH-1:0] w_next;
    logic             w_irq_take;
    logic             w_ill_take;

    assign w_pc_plus_4 = r_pc + WIDTH'(4);
    assign w_branch    = branch_taken ? (w_pc_plus_4 + (branch_offset << 2)) : w_pc_plus_4;

    // Jump and jr targets: jump always lands in user space; jr may only keep the kernel bit if already in kernel
    always_comb begin
        w_jump         = w_pc_plus_4;
        w_jump[27:0]   = {jump_index, 2'b00};
        w_jump[KBIT]   = 1'b0;
        w_jr           = jr_target;
        w_jr[KBIT]     = r_pc[KBIT] & jr_target[KBIT];
    end

    always_comb begin
        w_next = w_pc_plus_4;
        case (pcsrc)
            SRC_SEQ:    w_next = w_pc_plus_4;
            SRC_BRANCH: w_next = w_branch;
            SRC_JUMP:   w_next = w_jump;
            SRC_JR:     w_next = w_jr;
            default:    w_next = w_pc_plus_4;
        endcase
    end

    assign w_irq_take = (irq | r_irq_pending) & ~r_pc[KBIT] & ~stall;
    assign w_ill_take = pcsrc[2] & ~stall & ~w_irq_take;

    // Priority: reset > stall > interrupt > illegal op > selected target
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= RESET_VEC;
            r_epc         <= '0;
            r_exc_taken   <= 1'b0;
            r_irq_pending <= 1'b0;
            r_inst_count  <= '0;
        end else if (stall) begin
            r_exc_taken   <= 1'b0;
            r_irq_pending <= r_irq_pending | irq;
        end else if (w_irq_take) begin
            r_pc          <= XADR_VEC;
            r_epc         <= r_pc;
            r_exc_taken   <= 1'b1;
            r_irq_pending <= 1'b0;
        end else if (w_ill_take) begin
            r_pc          <= ILLOP_VEC;
            r_epc         <= w_pc_plus_4;
            r_exc_taken   <= 1'b1;
            r_irq_pending <= r_irq_pending | irq;
        end else begin
            r_pc          <= w_next;
            r_exc_taken   <= 1'b0;
            r_irq_pending <= r_irq_pending | irq;
            r_inst_count  <= r_inst_count + WIDTH'(1);
        end
    end

    assign pc          = r_pc;
    assign pc_plus_4   = w_pc_plus_4;
    assign kernel      = r_pc[KBIT];
    assign epc         = r_epc;
    assign exc_taken   = r_exc_taken;
    assign irq_pending = r_irq_pending;
    assign inst_count  = r_inst_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: walks reset, targets, kernel-bit rules,
// interrupt/illegal-op vectoring, counter wrap and asynchronous reset.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  pcsrc;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic        irq;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        kernel;
    logic [31:0] epc;
    logic        exc_taken;
    logic        irq_pending;
    logic [31:0] inst_count;

    int n_total = 0;
    int n_bad   = 0;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .pcsrc        (pcsrc),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump_index   (jump_index),
        .jr_target    (jr_target),
        .irq          (irq),
        .pc           (pc),
        .pc_plus_4    (pc_plus_4),
        .kernel       (kernel),
        .epc          (epc),
        .exc_taken    (exc_taken),
        .irq_pending  (irq_pending),
        .inst_count   (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic e_exc,
                             input logic e_pend, input logic [31:0] e_cnt);
        chk({tag, ".pc"},   pc, e_pc);
        chk({tag, ".exc"},  32'(exc_taken), 32'(e_exc));
        chk({tag, ".pend"}, 32'(irq_pending), 32'(e_pend));
        chk({tag, ".cnt"},  inst_count, e_cnt);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; pcsrc = 3'd0; branch_taken = 1'b0;
        branch_offset = '0; jump_index = '0; jr_target = '0; irq = 1'b0;

        // Reset values
        step();
        chk_state("rst", 32'h8000_0000, 1'b0, 1'b0, 32'd0);
        chk("rst.epc", epc, 32'h0);
        chk("rst.kernel", 32'(kernel), 32'd1);
        chk("rst.pc4", pc_plus_4, 32'h8000_0004);
        step();
        reset = 1'b1;

        // Sequential fetch
        step(); chk("seq1.pc", pc, 32'h8000_0004);
        step(); chk("seq2.pc", pc, 32'h8000_0008);
        step(); chk_state("seq3", 32'h8000_000C, 1'b0, 1'b0, 32'd3);

        // Branch taken / not taken from 00400010
        pcsrc = 3'd3; jr_target = 32'h0040_0010;
        step(); chk_state("jr_user", 32'h0040_0010, 1'b0, 1'b0, 32'd4);
        pcsrc = 3'd1; branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE;
        step(); chk_state("br_t", 32'h0040_000C, 1'b0, 1'b0, 32'd5);
        pcsrc = 3'd3; jr_target = 32'h0040_0010;
        step(); chk("br_setup.pc", pc, 32'h0040_0010);
        pcsrc = 3'd1; branch_taken = 1'b0;
        step(); chk_state("br_nt", 32'h0040_0014, 1'b0, 1'b0, 32'd7);

        // Illegal op from user, then jump/jr kernel-bit rules
        pcsrc = 3'd4;
        step(); chk_state("ill1", 32'h8000_0004, 1'b1, 1'b0, 32'd7);
        chk("ill1.epc", epc, 32'h0040_0018);
        pcsrc = 3'd3; jr_target = 32'h8000_0100;
        step(); chk_state("jr_kk", 32'h8000_0100, 1'b0, 1'b0, 32'd8);
        pcsrc = 3'd2; jump_index = 26'h000_0040;
        step(); chk_state("jump", 32'h0000_0100, 1'b0, 1'b0, 32'd9);
        chk("jump.kernel", 32'(kernel), 32'd0);
        pcsrc = 3'd3; jr_target = 32'h8000_0020;
        step(); chk("jr_u2k.pc", pc, 32'h0000_0020);
        chk("jr_u2k.kernel", 32'(kernel), 32'd0);
        pcsrc = 3'd5;
        step(); chk("ill5.pc", pc, 32'h8000_0004);
        chk("ill5.epc", epc, 32'h0000_0024);
        pcsrc = 3'd3; jr_target = 32'h8000_0020;
        step(); chk_state("jr_k2k", 32'h8000_0020, 1'b0, 1'b0, 32'd11);

        // Interrupt arriving during a stall
        jr_target = 32'h0000_0040;
        step(); chk("to40.pc", pc, 32'h0000_0040);
        pcsrc = 3'd0; stall = 1'b1; irq = 1'b1;
        step(); chk_state("stall_irq", 32'h0000_0040, 1'b0, 1'b1, 32'd12);
        irq = 1'b0;
        step(); chk_state("stall_hold", 32'h0000_0040, 1'b0, 1'b1, 32'd12);
        stall = 1'b0;
        step(); chk_state("irq_take", 32'h8000_0008, 1'b1, 1'b0, 32'd12);
        chk("irq_take.epc", epc, 32'h0000_0040);
        step(); chk_state("post_irq", 32'h8000_000C, 1'b0, 1'b0, 32'd13);

        // Kernel masking: irq latched until jr drops back to user
        irq = 1'b1;
        step(); chk_state("kmask", 32'h8000_0010, 1'b0, 1'b1, 32'd14);
        irq = 1'b0; pcsrc = 3'd3; jr_target = 32'h0000_0200;
        step(); chk_state("jr_out", 32'h0000_0200, 1'b0, 1'b1, 32'd15);
        pcsrc = 3'd0;
        step(); chk_state("late_irq", 32'h8000_0008, 1'b1, 1'b0, 32'd15);
        chk("late_irq.epc", epc, 32'h0000_0200);

        // Simultaneous irq and illop: irq wins with epc=pc
        pcsrc = 3'd3; jr_target = 32'h0000_0300;
        step(); chk("to300.pc", pc, 32'h0000_0300);
        pcsrc = 3'd4; irq = 1'b1;
        step(); chk_state("irq_ill", 32'h8000_0008, 1'b1, 1'b0, 32'd16);
        chk("irq_ill.epc", epc, 32'h0000_0300);
        irq = 1'b0;

        // Illop under stall is ignored, then taken at 00000080
        pcsrc = 3'd3; jr_target = 32'h0000_0080;
        step(); chk("to80.pc", pc, 32'h0000_0080);
        pcsrc = 3'd4; stall = 1'b1;
        step(); chk_state("ill_stall", 32'h0000_0080, 1'b0, 1'b0, 32'd17);
        stall = 1'b0;
        step(); chk_state("ill80", 32'h8000_0004, 1'b1, 1'b0, 32'd17);
        chk("ill80.epc", epc, 32'h0000_0084);

        // Retire counter wraps from all-ones to zero
        pcsrc = 3'd0;
        force dut.r_inst_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_inst_count;
        chk("wrap.pre", inst_count, 32'hFFFF_FFFF);
        step(); chk_state("wrap", 32'h8000_0008, 1'b0, 1'b0, 32'd0);

        // Asynchronous reset between edges drops the pending irq
        irq = 1'b1;
        step(); chk_state("pre_arst", 32'h8000_000C, 1'b0, 1'b1, 32'd1);
        irq = 1'b0; stall = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk_state("arst", 32'h8000_0000, 1'b0, 1'b0, 32'd0);
        chk("arst.epc", epc, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
